// File: rtl/mapper_pkg.sv
// -----------------------------------------------------------------------------
// mapper_pkg
//   Framing constants shared by the transmit mapper and the receive demapper:
//   frame alignment bytes, CRC-8 polynomial, overhead (OH) byte layout and the
//   framer FSM state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package mapper_pkg;

  localparam logic [7:0] FAS0_BYTE = 8'hF6;
  localparam logic [7:0] FAS1_BYTE = 8'h28;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  // OH byte layout: bit 7 = ARQ flag, bits 6:0 = zero-padded sequence number.
  localparam int OH_ARQ_BIT  = 7;
  localparam int OH_SEQ_BITS = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FAS0,
    ST_FAS1,
    ST_OH,
    ST_PYLD,
    ST_CRC,
    ST_WAIT_ACK
  } state_t;

  function automatic logic [7:0] oh_byte(input logic arq, input logic [OH_SEQ_BITS-1:0] seq);
    logic [7:0] w_oh;
    w_oh = {1'b0, seq};
    w_oh[OH_ARQ_BIT] = arq;
    return w_oh;
  endfunction

endpackage

// File: rtl/mapper_if.sv
// -----------------------------------------------------------------------------
// mapper_if
//   Handshake bundle of the transmit framer:
//     payload stream in  : i_pyld_data, i_pyld_data_valid, o_pyld_data_ready
//     frame stream out   : o_frame_data, o_frame_data_valid, o_frame_data_fas,
//                          i_frame_data_ready
//     ACK receiver input : i_ack_valid, i_ack_ok
//   Signal prefixes are from the framer's point of view.
//   modport master : the framer (drives o_*)
//   modport slave  : its environment (drives i_*)
// -----------------------------------------------------------------------------
interface mapper_if;

  logic [7:0] i_pyld_data;
  logic       i_pyld_data_valid;
  logic       o_pyld_data_ready;

  logic [7:0] o_frame_data;
  logic       o_frame_data_valid;
  logic       o_frame_data_fas;
  logic       i_frame_data_ready;

  logic       i_ack_valid;
  logic       i_ack_ok;

  modport master (
    input  i_pyld_data, i_pyld_data_valid, i_frame_data_ready, i_ack_valid, i_ack_ok,
    output o_pyld_data_ready, o_frame_data, o_frame_data_valid, o_frame_data_fas
  );

  modport slave (
    output i_pyld_data, i_pyld_data_valid, i_frame_data_ready, i_ack_valid, i_ack_ok,
    input  o_pyld_data_ready, o_frame_data, o_frame_data_valid, o_frame_data_fas
  );

endinterface

// File: rtl/mapper_crc8_update.sv
// -----------------------------------------------------------------------------
// crc8_update
//   Combinational one-byte CRC-8 step: polynomial 0x07, MSB first, no
//   reflection, no final XOR.
//   i_crc  in  8  running CRC
//   i_byte in  8  next message byte
//   o_crc  out 8  updated CRC
// -----------------------------------------------------------------------------
module crc8_update
  import mapper_pkg::*;
(
  input  logic [7:0] i_crc,
  input  logic [7:0] i_byte,
  output logic [7:0] o_crc
);

  logic [7:0] w_c;

  // NOTE: combinational logic uses blocking '=' and assigns every variable
  // before any conditional use, so the loop unrolls into gates with no latch.
  always_comb begin
    w_c = i_crc ^ i_byte;
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[7] ? ((w_c << 1) ^ CRC_POLY) : (w_c << 1);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/mapper.sv
// -----------------------------------------------------------------------------
// mapper
//   Transmit framer. Builds FAS0, FAS1, OH, PYLD_LEN payload bytes, CRC-8 from
//   a payload byte stream and emits them through a single output register.
//   With ARQ latched at frame start, the payload is kept in a small buffer and
//   the frame is replayed on NACK or ACK timeout, up to MAX_RETX times.
//   i_clk       in  1  clock
//   i_rst       in  1  synchronous active-high reset
//   i_arq_en    in  1  ARQ enable, sampled on leaving IDLE
//   o_retx_fail out 1  one-cycle pulse when a frame is dropped
//   bus         --     mapper_if.master (payload in, frame out, ACK strobes)
// -----------------------------------------------------------------------------
module mapper
  import mapper_pkg::*;
#(
  parameter int         PYLD_LEN    = 16,
  parameter logic [7:0] FAS0        = FAS0_BYTE,
  parameter logic [7:0] FAS1        = FAS1_BYTE,
  parameter int         ACK_TIMEOUT = 4096,
  parameter int         MAX_RETX    = 3,
  parameter int         SEQ_W       = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_arq_en,
  output logic      o_retx_fail,
  mapper_if.master  bus
);

  localparam int IDX_W = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RC_W  = (MAX_RETX > 0) ? $clog2(MAX_RETX + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PYLD_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [RC_W-1:0]  MAX_RC   = RC_W'(MAX_RETX);

  state_t           r_state;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_fas;
  logic             r_arq;
  logic             r_replay;
  logic [7:0]       r_crc;
  logic [SEQ_W-1:0] r_seq;
  logic [IDX_W-1:0] r_idx;
  logic [TMR_W-1:0] r_timer;
  logic [RC_W-1:0]  r_retx_cnt;
  logic             r_retx_fail;
  logic [7:0]       r_buf [PYLD_LEN];

  logic       w_load;
  logic       w_pyld_take;
  logic [7:0] w_pyld_byte;
  logic [7:0] w_oh;
  logic [7:0] w_crc_byte;
  logic [7:0] w_crc_next;
  logic       w_ack;
  logic       w_retry;

  // The output register may take a new byte when it is empty or being drained.
  assign w_load      = !r_valid || bus.i_frame_data_ready;
  assign w_pyld_take = (r_state == ST_PYLD) && !r_replay && w_load && bus.i_pyld_data_valid;
  assign w_pyld_byte = r_replay ? r_buf[r_idx] : bus.i_pyld_data;
  assign w_oh        = oh_byte(r_arq, OH_SEQ_BITS'(r_seq));
  // CRC is zero when OH is loaded, so one update instance covers OH and payload.
  assign w_crc_byte  = (r_state == ST_OH) ? w_oh : w_pyld_byte;

  // ACK beats a simultaneous timeout; a NACK behaves like a timeout.
  assign w_ack   = bus.i_ack_valid && bus.i_ack_ok;
  assign w_retry = (bus.i_ack_valid && !bus.i_ack_ok) || (r_timer == TMR_LAST);

  crc8_update u_crc8_update (
    .i_crc  (r_crc),
    .i_byte (w_crc_byte),
    .o_crc  (w_crc_next)
  );

  // NOTE: the buffer is plain storage with no reset, so it maps onto
  // distributed RAM; every entry is written before a replay can read it.
  always_ff @(posedge i_clk) begin
    if (w_pyld_take) r_buf[r_idx] <= bus.i_pyld_data;
  end

  // NOTE: all state registers use non-blocking '<=' so every register samples
  // the pre-edge value of every other one, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_fas       <= 1'b0;
      r_arq       <= 1'b0;
      r_replay    <= 1'b0;
      r_crc       <= 8'h00;
      r_seq       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_retx_cnt  <= '0;
      r_retx_fail <= 1'b0;
    end else begin
      r_retx_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_load) r_valid <= 1'b0;
          if (bus.i_pyld_data_valid) begin
            r_arq   <= i_arq_en;
            r_state <= ST_FAS0;
          end
        end
        ST_FAS0: begin
          if (w_load) begin
            r_data  <= FAS0;
            r_valid <= 1'b1;
            r_fas   <= 1'b1;
            r_crc   <= 8'h00;
            r_state <= ST_FAS1;
          end
        end
        ST_FAS1: begin
          if (w_load) begin
            r_data  <= FAS1;
            r_valid <= 1'b1;
            r_fas   <= 1'b1;
            r_state <= ST_OH;
          end
        end
        ST_OH: begin
          if (w_load) begin
            r_data  <= w_oh;
            r_valid <= 1'b1;
            r_fas   <= 1'b0;
            r_crc   <= w_crc_next;
            r_idx   <= '0;
            r_state <= ST_PYLD;
          end
        end
        ST_PYLD: begin
          if (w_load) begin
            if (r_replay || bus.i_pyld_data_valid) begin
              r_data  <= w_pyld_byte;
              r_valid <= 1'b1;
              r_crc   <= w_crc_next;
              if (r_idx == LAST_IDX) begin
                r_idx   <= '0;
                r_state <= ST_CRC;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              // Input starved: pause without inserting filler.
              r_valid <= 1'b0;
            end
          end
        end
        ST_CRC: begin
          if (w_load) begin
            r_data   <= r_crc;
            r_valid  <= 1'b1;
            r_replay <= 1'b0;
            if (r_arq) begin
              r_timer <= '0;
              r_state <= ST_WAIT_ACK;
            end else begin
              r_seq   <= r_seq + 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_WAIT_ACK: begin
          if (w_load) r_valid <= 1'b0;
          r_timer <= r_timer + 1'b1;
          if (w_ack) begin
            r_seq      <= r_seq + 1'b1;
            r_retx_cnt <= '0;
            r_state    <= ST_IDLE;
          end else if (w_retry) begin
            if (r_retx_cnt < MAX_RC) begin
              r_retx_cnt <= r_retx_cnt + 1'b1;
              r_replay   <= 1'b1;
              r_state    <= ST_FAS0;
            end else begin
              r_retx_fail <= 1'b1;
              r_seq       <= r_seq + 1'b1;
              r_retx_cnt  <= '0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_pyld_data_ready  = (r_state == ST_PYLD) && !r_replay && w_load;
  assign bus.o_frame_data       = r_data;
  assign bus.o_frame_data_valid = r_valid;
  assign bus.o_frame_data_fas   = r_fas;
  assign o_retx_fail            = r_retx_fail;

endmodule
